// File: rtl/ats21_pkg.sv
// Shared types for the ATS21 command arbiter: opcodes, client FSM states,
// target keys and the device mode/permission record.
package ats21_pkg;

  localparam int NUM_CLOCKS = 16;
  localparam int NUM_ALARMS = 24;
  localparam int CLK_IDX_W  = $clog2(NUM_CLOCKS);
  localparam int KEY_IDX_W  = $clog2(NUM_ALARMS);
  localparam int BEAT_W     = 16;
  localparam int WORD_W     = 2 * BEAT_W;

  // Field positions inside the assembled 32-bit instruction.
  localparam int OPC_LSB      = 29;
  localparam int MODE_ACT_BIT = 28;
  localparam int MODE_ALM_BIT = 26;
  localparam int MODE_CLK_BIT = 24;

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_SET_CLK = 3'b001,
    OP_EN_CLK  = 3'b010,
    OP_MODE    = 3'b011,
    OP_SET_ALM = 3'b101,
    OP_SET_TMR = 3'b110,
    OP_EN_ALM  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    CL_IDLE = 2'd0,
    CL_HI   = 2'd1,
    CL_PEND = 2'd2
  } client_st_e;

  typedef struct packed {
    logic                 is_mode;
    logic                 is_alm;
    logic [KEY_IDX_W-1:0] idx;
  } key_t;

  typedef struct packed {
    logic       active;
    logic [1:0] allow_clk;
    logic [1:0] allow_alm;
  } mode_t;

  function automatic logic is_clk_op(input logic [2:0] op);
    return (op == OP_SET_CLK) || (op == OP_EN_CLK);
  endfunction

  function automatic logic is_alm_op(input logic [2:0] op);
    return (op == OP_SET_ALM) || (op == OP_SET_TMR) || (op == OP_EN_ALM);
  endfunction

  function automatic logic is_legal_op(input logic [2:0] op);
    return is_clk_op(op) || is_alm_op(op) || (op == OP_MODE);
  endfunction

endpackage

// File: rtl/ats21_beat_assembler.sv
// Per-client two-beat instruction assembler: IDLE -> HI -> PEND, held in PEND
// until the arbiter releases it.
module ats21_beat_assembler
  import ats21_pkg::*;
(
  input  logic              clk_1x,
  input  logic              reset,
  input  logic              req_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic              release_i,
  output logic              pend_o,
  output logic              abort_o,
  output logic [WORD_W-1:0] word_o
);

  client_st_e        state_q;
  logic              pend_q;
  logic [BEAT_W-1:0] hi_q;
  logic [BEAT_W-1:0] lo_q;
  logic              start;

  assign start = req_i && (beat_i[BEAT_W-1 -: 3] != OP_NOP);

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      state_q <= CL_IDLE;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        CL_IDLE: if (start) state_q <= CL_HI;
        CL_HI: begin
          state_q <= req_i ? CL_PEND : CL_IDLE;
          pend_q  <= req_i;
        end
        CL_PEND: if (release_i) begin
          state_q <= CL_IDLE;
          pend_q  <= 1'b0;
        end
        default: begin
          state_q <= CL_IDLE;
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  // Beat payload is pure data; only the FSM above needs a reset.
  always_ff @(posedge clk_1x) begin
    if (state_q == CL_IDLE && start) hi_q <= beat_i;
    if (state_q == CL_HI && req_i)   lo_q <= beat_i;
  end

  assign pend_o  = pend_q;
  assign abort_o = (state_q == CL_HI) && !req_i;
  assign word_o  = {hi_q, lo_q};

endmodule

// File: rtl/ats21_cmd_arbiter.sv
// Two-client ATS21 command arbiter: assembles beats, resolves conflicts and
// permissions, executes mode commands internally and issues the rest.
module ats21_cmd_arbiter
  import ats21_pkg::*;
#(
  parameter int CMD_W = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk_1x,
  input  logic             reset,
  input  logic             req,
  input  logic [15:0]      ctrlA,
  input  logic [15:0]      ctrlB,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [CMD_W-1:0] cmd_word,
  output logic             cmd_src,
  output logic [1:0]       busy,
  output logic [1:0]       stat_vld,
  output logic [1:0]       stat,
  output logic             mode_active
);

  function automatic key_t make_key(input logic [WORD_W-1:0] w);
    key_t k;
    k = '0;
    if (is_clk_op(w[OPC_LSB +: 3])) begin
      k.idx = KEY_IDX_W'(w[25 +: CLK_IDX_W]);
    end else if (is_alm_op(w[OPC_LSB +: 3])) begin
      k.is_alm = 1'b1;
      k.idx    = KEY_IDX_W'(w[24 +: IDX_W]);
    end else if (w[OPC_LSB +: 3] == OP_MODE) begin
      k.is_mode = 1'b1;
    end
    return k;
  endfunction

  logic [1:0]        pend, abort, rel, cand;
  logic [WORD_W-1:0] word_a, word_b, g_word;
  logic [2:0]        op;
  logic              hs, dec_en, conflict, decide, grant_b;
  logic              permit, issue, exec, nack;
  logic [1:0]        gsel, ack_hs;

  logic             cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0] cmd_word_q, cmd_word_d;
  logic             cmd_src_q, cmd_src_d;
  logic [1:0]       stat_vld_q, stat_vld_d;
  logic [1:0]       stat_q, stat_d;
  logic             rr_b_q, rr_b_d;
  mode_t            mode_q, mode_d;

  ats21_beat_assembler u_asm_a (
    .clk_1x    (clk_1x),
    .reset     (reset),
    .req_i     (req),
    .beat_i    (ctrlA),
    .release_i (rel[0]),
    .pend_o    (pend[0]),
    .abort_o   (abort[0]),
    .word_o    (word_a)
  );

  ats21_beat_assembler u_asm_b (
    .clk_1x    (clk_1x),
    .reset     (reset),
    .req_i     (req),
    .beat_i    (ctrlB),
    .release_i (rel[1]),
    .pend_o    (pend[1]),
    .abort_o   (abort[1]),
    .word_o    (word_b)
  );

  always_comb begin
    hs      = cmd_valid_q & cmd_ready;
    dec_en  = ~cmd_valid_q | hs;
    // The client whose command is on the bus is not a candidate again.
    cand[0] = pend[0] & ~(cmd_valid_q & ~cmd_src_q);
    cand[1] = pend[1] & ~(cmd_valid_q & cmd_src_q);

    conflict = dec_en & cand[0] & cand[1]
             & is_legal_op(word_a[OPC_LSB +: 3]) & is_legal_op(word_b[OPC_LSB +: 3])
             & (make_key(word_a) == make_key(word_b));
    grant_b  = cand[1] & (~cand[0] | rr_b_q);
    decide   = dec_en & (|cand) & ~conflict;

    g_word = grant_b ? word_b : word_a;
    op     = g_word[OPC_LSB +: 3];
    permit = mode_q.active
           & ((is_clk_op(op) & mode_q.allow_clk[grant_b])
            | (is_alm_op(op) & mode_q.allow_alm[grant_b]));
    exec   = decide & (op == OP_MODE);
    issue  = decide & (op != OP_MODE) & permit;
    nack   = decide & (op != OP_MODE) & ~permit;

    gsel   = {grant_b, ~grant_b};
    ack_hs = hs ? {cmd_src_q, ~cmd_src_q} : 2'b00;
    rel    = ack_hs | (conflict ? 2'b11 : 2'b00) | ((exec | nack) ? gsel : 2'b00);

    stat_vld_d = rel | abort;
    stat_d     = ack_hs | (exec ? gsel : 2'b00);

    cmd_valid_d = (cmd_valid_q & ~hs) | issue;
    cmd_word_d  = issue ? CMD_W'(g_word) : cmd_word_q;
    cmd_src_d   = issue ? grant_b : cmd_src_q;
    rr_b_d      = (decide & cand[0] & cand[1]) ? ~grant_b : rr_b_q;

    mode_d = mode_q;
    if (exec) begin
      mode_d.active             = g_word[MODE_ACT_BIT];
      mode_d.allow_alm[grant_b] = g_word[MODE_ALM_BIT];
      mode_d.allow_clk[grant_b] = g_word[MODE_CLK_BIT];
    end
  end

  always_ff @(posedge clk_1x or posedge reset) begin
    if (reset) begin
      cmd_valid_q <= 1'b0;
      cmd_word_q  <= '0;
      cmd_src_q   <= 1'b0;
      stat_vld_q  <= 2'b00;
      stat_q      <= 2'b00;
      rr_b_q      <= 1'b0;
      mode_q      <= '{active: 1'b1, allow_clk: 2'b11, allow_alm: 2'b11};
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_word_q  <= cmd_word_d;
      cmd_src_q   <= cmd_src_d;
      stat_vld_q  <= stat_vld_d;
      stat_q      <= stat_d;
      rr_b_q      <= rr_b_d;
      mode_q      <= mode_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_word    = cmd_word_q;
  assign cmd_src     = cmd_src_q;
  assign busy        = pend;
  assign stat_vld    = stat_vld_q;
  assign stat        = stat_q;
  assign mode_active = mode_q.active;

endmodule

// File: doc/ats21_cmd_arbiter.md
ATS21_CMD_ARBITER -- requirements
Module: ats21_cmd_arbiter

Interface
REQ-001 The block SHALL have parameter CMD_W, default 32: assembled instruction width, two 16-bit beats.
REQ-002 The block SHALL have parameter IDX_W, default 5: target index width (alarm 0-23, clock 0-15).
REQ-003 The block SHALL have port clk_1x  in  1: clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset  in  1: reset, asynchronous, active-high.
REQ-005 The block SHALL have port req  in  1: beat qualifier shared by both clients.
REQ-006 The block SHALL have ports ctrlA / ctrlB  in  16 each: client A / B beat, high half first.
REQ-007 The block SHALL have port cmd_valid  out  1: issued command valid.
REQ-008 The block SHALL have port cmd_ready  in  1: ATS21 core accepts the command.
REQ-009 The block SHALL have port cmd_word  out  CMD_W: issued instruction.
REQ-010 The block SHALL have port cmd_src  out  1: issuing client, 0=A, 1=B.
REQ-011 The block SHALL have port busy  out  2: client holds a pending instruction; [0]=A, [1]=B.
REQ-012 The block SHALL have port stat_vld  out  2: one-cycle status pulse per client.
REQ-013 The block SHALL have port stat  out  2: 1=Ack, 0=Nack; valid only with stat_vld.
REQ-014 The block SHALL have port mode_active  out  1: device-active mode bit.

Function
REQ-015 Each client SHALL run FSM IDLE->HI->PEND.
- IDLE->HI: req=1 and beat[15:13]!=000; latch high half.
- Beat[15:13]=000 (nop) SHALL be ignored.
REQ-016 HI, req=1: latch low half, ->PEND; HI, req=0: ->IDLE, Nack pulse, nothing issued.
REQ-017 PEND: beats ignored, busy=1; PEND->IDLE only on decision (issue handshake, Nack, or internal execute).
REQ-018 Target key per opcode:
- 001/010: {0, word[28:25]}.
- 101/110/111: {1, word[28:24]}.
- 011: MODE.
- 000/100: illegal.
REQ-019 Decision stage: one decision per cycle, only when cmd_valid=0 or a cmd_valid&cmd_ready handshake occurs that cycle.
REQ-020 Both PEND with equal keys (incl. both MODE): both SHALL be Nacked the same cycle, both ->IDLE, nothing issued.
REQ-021 Both PEND with distinct keys: round-robin; grant the client not granted last; after reset A has priority.
REQ-022 Permission check:
- illegal opcode -> Nack.
- mode_active=0 -> Nack all except 011.
- 001/010 need allow_clk[client]; 101/110/111 need allow_alm[client].
REQ-023 Opcode 011 SHALL execute internally, never issued:
- mode_active<=word[28].
- allow_alm[client]<=word[26]; allow_clk[client]<=word[24].
- Ack.
REQ-024 A permitted command SHALL drive cmd_valid=1 the cycle after its decision, holding cmd_word/cmd_src stable until cmd_ready.
REQ-025 Ack SHALL be pulsed the cycle after the handshake; the client ->IDLE on the handshake edge.
REQ-026 Latency: beats sampled at edges n and n+1 -> earliest cmd_valid in the cycle after edge n+2.
- Idle-client Ack SHALL appear 1 cycle after cmd_ready.
REQ-027 Nack/internal-execute status SHALL pulse the cycle after the decision.
REQ-028 Both stat_vld bits MAY assert in the same cycle.
REQ-029 A client released to IDLE SHALL accept a new high beat on the very next edge.

Reset
REQ-030 On reset assertion, asynchronously:
- FSMs -> IDLE.
- cmd_valid=0, cmd_word=0, cmd_src=0.
- busy=00, stat_vld=00, stat=00.
- mode_active=1, allow_clk=allow_alm=11.
- round-robin pointer favours A.
REQ-031 A reset mid-handshake SHALL drop cmd_valid with no status pulse.
REQ-032 Post-reset operation SHALL begin at the first clk_1x edge after reset deasserts.

Structure
REQ-033 Package ats21_pkg SHALL hold:
- opcode enum (NOP, SET_CLK, EN_CLK, MODE, SET_ALM, SET_TMR, EN_ALM).
- client state enum; target key typedef; mode struct.
- NUM_CLOCKS=16, NUM_ALARMS=24.
REQ-034 Sub-module ats21_beat_assembler (per-client IDLE/HI/PEND FSM) SHALL be instantiated twice; arbitration/permission/mode logic stays in the top.

Verification
REQ-035 Clock set: A beats 16'h2180,16'h0010, cmd_ready=1 -> cmd_word=32'h21800010, cmd_src=0; Ack on A 1 cycle after handshake.
REQ-036 Conflict: A and B both send 0xA300/0x0005 (alarm 3) same cycles -> stat_vld=11, stat=00, no cmd_valid.
REQ-037 Round-robin: A clock 1 and B clock 2 pending simultaneously, cmd_ready=1 -> A issued then B next cycle; repeat -> B first.
REQ-038 Permission: A sends 16'h6000/16'h0000 (mode: active=0) -> Ack; then B 16'hA100/16'h0007 -> Nack, no issue.
REQ-039 Abort/backpressure: A high beat then req=0 -> Nack pulse, busy[0]=0; with cmd_ready=0 for 5 cycles cmd_word stays stable and beats are ignored.
REQ-040 Reset mid-handshake: reset with cmd_valid=1 -> all outputs per REQ-030 immediately; new beat accepted after release.
